// File: rtl/shreg_pkg.sv
// Shared types and helpers for the serial-link deserializer and its transmitter.
package shreg_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // XOR-reduce a zero-extended word; a 1 means odd population.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/shreg_hold_reg.sv
// One-entry valid/ready holding register with overrun detect.
// Carries a parity-error flag alongside the word when SHREG_PARITY_EN is defined.
module shreg_hold_reg
  import shreg_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
`ifdef SHREG_PARITY_EN
  input  logic             wr_perr_i,
  output logic             perr_o,
`endif
  input  logic             rd_ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
`ifdef SHREG_PARITY_EN
  logic             perr_q, perr_d;
`endif

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
`ifdef SHREG_PARITY_EN
    perr_d    = perr_q;
`endif
    if (wr_en_i) begin
      // A slot freed on this same edge can take the new word.
      if (!valid_q || rd_ready_i) begin
        data_d  = wr_data_i;
        valid_d = 1'b1;
`ifdef SHREG_PARITY_EN
        perr_d  = wr_perr_i;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && rd_ready_i) begin
      valid_d = 1'b0;
`ifdef SHREG_PARITY_EN
      perr_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SHREG_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
`ifdef SHREG_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;
`ifdef SHREG_PARITY_EN
  assign perr_o    = perr_q;
`endif

endmodule

// File: rtl/shiftreg_deser.sv
// Serial-in, parallel-out receiver: MSB-first shift register, bit counter and FSM.
// Define SHREG_PARITY_EN to append an even-parity bit to each frame.
module shiftreg_deser
  import shreg_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             shift_in,
  input  logic             shift_clr,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
`ifdef SHREG_PARITY_EN
  output logic             parity_err,
`endif
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
`ifdef SHREG_PARITY_EN
  localparam int unsigned LAST  = WIDTH;
`else
  localparam int unsigned LAST  = WIDTH - 1;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             busy_q, busy_d;
  logic             complete_c;
  logic [WIDTH-1:0] word_c;

`ifdef SHREG_PARITY_EN
  // Data bits are already in sr_q; the bit on the wire is the parity bit.
  logic perr_c;
  assign word_c = sr_q;
  assign perr_c = even_parity(32'(sr_q)) ^ shift_in;
`else
  logic unused_msb;
  assign word_c     = {sr_q[WIDTH-2:0], shift_in};
  assign unused_msb = sr_q[WIDTH-1];
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    complete_c = 1'b0;
    if (shift_clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      sr_d    = '0;
    end else if (shift_en) begin
      if (cnt_q == CNT_W'(LAST)) begin
        complete_c = 1'b1;
        state_d    = ST_IDLE;
        cnt_d      = '0;
        sr_d       = '0;
      end else begin
        state_d = ST_SHIFT;
        cnt_d   = cnt_q + CNT_W'(1);
        sr_d    = {sr_q[WIDTH-2:0], shift_in};
      end
    end
    busy_d = (state_d == ST_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

  shreg_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (complete_c),
    .wr_data_i  (word_c),
`ifdef SHREG_PARITY_EN
    .wr_perr_i  (perr_c),
    .perr_o     (parity_err),
`endif
    .rd_ready_i (word_ready),
    .data_o     (word_out),
    .valid_o    (word_valid),
    .overrun_o  (overrun)
  );

endmodule
